trans_d_out: RTL and testbench

Result write-back packer: the store-direction counterpart of the AXI→SRAM/systolic load transform. After a tile computation it accepts the 8×8 result sub-tiles of D from the systolic array one at a time, truncates each element to the operand width of the active `data_type`, and emits 256-bit write beats to the AXI write master. Every beat carries the element's D row/column so the master can form addresses. A full D tile (256 elements: M32N8, M16N16 or M8N32) always takes exactly 4 sub-tiles and 32 beats, matching the fixed 32-beat C load.

---
 rtl/trans_d_out.sv | 192 +++++++++++++++++++
 tb/tb_trans_d_out.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trans_d_out.sv
//------------------------------------------------------------------------------
// trans_d_out: D-tile write-back packer, 8x8 result sub-tiles to 256-bit beats. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package params;
  localparam int ARR   = 8;
  localparam int PE_W  = 32;
  localparam int AXI_W = 256;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    INT8 = 2'd2,
    INT4 = 2'd3
  } type_t;

  typedef logic [1:0] rc_t;
endpackage

module trans_d_out import params::*; (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  type_t                                 data_type,
  input  rc_t                                   rc,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  input  logic                                  tile_valid,
  output logic                                  tile_ready,
  input  logic [ARR-1:0][ARR-1:0][PE_W-1:0]     tile_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [AXI_W-1:0]                      out_data,
  output logic [AXI_W/8-1:0]                    out_strb,
  output logic [4:0]                            out_burst_num,
  output logic [4:0]                            out_row,
  output logic [4:0]                            out_col,
  output logic                                  out_last
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TILE = 2'd1,
    S_SEND      = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  function automatic logic [AXI_W-1:0] f_pack(input logic [ARR-1:0][PE_W-1:0] row, input type_t dt);
    logic [AXI_W-1:0] v;
    v = '0;
    for (int c = 0; c < ARR; c++) begin
      case (dt)
        FP32:    v[c*32 +: 32] = row[c];
        FP16:    v[c*16 +: 16] = row[c][15:0];
        INT8:    v[c*8  +: 8]  = row[c][7:0];
        default: v[c*4  +: 4]  = row[c][3:0];
      endcase
    end
    return v;
  endfunction

  function automatic logic [AXI_W/8-1:0] f_strb(input type_t dt);
    case (dt)
      FP32:    return 32'hFFFF_FFFF;
      FP16:    return 32'h0000_FFFF;
      INT8:    return 32'h0000_00FF;
      default: return 32'h0000_000F;
    endcase
  endfunction

  function automatic logic [4:0] f_row(input rc_t shape, input logic [1:0] s, input logic [2:0] r);
    case (shape)
      2'b00:   return {s, r};
      2'b01:   return {1'b0, s[1], r};
      default: return {2'b00, r};
    endcase
  endfunction

  function automatic logic [4:0] f_col(input rc_t shape, input logic [1:0] s);
    case (shape)
      2'b00:   return 5'd0;
      2'b01:   return {1'b0, s[0], 3'b000};
      default: return {s, 3'b000};
    endcase
  endfunction

  state_t                          r_state;
  type_t                           r_dtype;
  rc_t                             r_rc;
  logic [1:0]                      r_s;
  logic [2:0]                      r_r;
  // Row 0 goes straight from tile_data into the output register, so only rows 1..7 are held.
  logic [ARR-1:1][ARR-1:0][PE_W-1:0] r_buf;

  logic                            w_cap;
  logic                            w_hs;
  logic [2:0]                      w_nr;
  logic [ARR-1:0][PE_W-1:0]        w_row_src;
  logic [AXI_W-1:0]                w_beat_data;

  always_comb begin
    w_cap       = (r_state == S_WAIT_TILE) && tile_valid;
    w_hs        = out_valid && out_ready;
    w_nr        = w_cap ? 3'd0 : (r_r + 3'd1);
    w_row_src   = w_cap ? tile_data[0] : r_buf[w_nr];
    w_beat_data = f_pack(w_row_src, r_dtype);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_dtype       <= FP32;
      r_rc          <= 2'b00;
      r_s           <= 2'd0;
      r_r           <= 3'd0;
      r_buf         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      tile_ready    <= 1'b0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_data      <= '0;
      out_strb      <= '0;
      out_burst_num <= '0;
      out_row       <= '0;
      out_col       <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (rc == 2'b11) begin
              err <= 1'b1;
            end else begin
              r_dtype    <= data_type;
              r_rc       <= rc;
              r_s        <= 2'd0;
              r_r        <= 3'd0;
              r_state    <= S_WAIT_TILE;
              busy       <= 1'b1;
              tile_ready <= 1'b1;
            end
          end
        end
        S_WAIT_TILE: begin
          if (w_cap) begin
            r_buf      <= tile_data[ARR-1:1];
            r_state    <= S_SEND;
            tile_ready <= 1'b0;
          end
        end
        S_SEND: begin
          if (w_hs && r_r == 3'd7) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (r_s == 2'd3) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_s        <= r_s + 2'd1;
              r_state    <= S_WAIT_TILE;
              tile_ready <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase

      // New beat: first row right after capture, or the next row after a handshake.
      if (w_cap || (r_state == S_SEND && w_hs && r_r != 3'd7)) begin
        r_r           <= w_nr;
        out_valid     <= 1'b1;
        out_data      <= w_beat_data;
        out_strb      <= f_strb(r_dtype);
        out_burst_num <= {r_s, w_nr};
        out_row       <= f_row(r_rc, r_s, w_nr);
        out_col       <= f_col(r_rc, r_s);
        out_last      <= (r_s == 2'd3) && (w_nr == 3'd7);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trans_d_out.sv
//------------------------------------------------------------------------------
// tb_trans_d_out: scoreboard bench for the D-tile write-back packer. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_trans_d_out;
  import params::*;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      start;
  type_t                     data_type;
  logic [1:0]                rc;
  logic                      busy, done, err;
  logic                      tile_valid, tile_ready;
  logic [7:0][7:0][31:0]     tile_data;
  logic                      out_valid, out_ready;
  logic [255:0]              out_data;
  logic [31:0]               out_strb;
  logic [4:0]                out_burst_num, out_row, out_col;
  logic                      out_last;

  always #5 clk = ~clk;

  trans_d_out u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_type(data_type), .rc(rc),
    .busy(busy), .done(done), .err(err),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_data(tile_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_strb(out_strb),
    .out_burst_num(out_burst_num), .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [4:0]   bn;
    logic [4:0]   row;
    logic [4:0]   col;
    logic         last;
  } beat_t;

  beat_t        q[$];
  beat_t        cur, prev, expb;
  logic         prev_stall = 1'b0;
  int           checks = 0, errors = 0;
  type_t        m_dt = FP32;
  logic [1:0]   m_rc = 2'b00;
  int           m_s = 0;
  int           ncyc = 0, beats_seen = 0, last_beat_n = 0, done_n = 0, done_cnt = 0, start_n = 0;
  logic [255:0] sv_data[32];
  logic [31:0]  sv_strb[32];
  logic [4:0]   sv_row[32], sv_col[32];
  logic         sv_last[32];

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t f_exp(input logic [7:0][7:0][31:0] t, input type_t dt,
                                  input logic [1:0] shape, input int s, input int r);
    beat_t b;
    int    w;
    b = '0;
    w = 32 >> int'(dt);
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < w; k++)
        b.data[c*w + k] = t[r][c][k];
    b.strb = 32'((64'd1 << w) - 64'd1);
    b.bn   = 5'(s * 8 + r);
    case (shape)
      2'b00:   begin b.row = 5'(s * 8 + r);       b.col = 5'd0; end
      2'b01:   begin b.row = 5'((s / 2) * 8 + r); b.col = 5'((s % 2) * 8); end
      default: begin b.row = 5'(r);               b.col = 5'(s * 8); end
    endcase
    b.last = (s == 3) && (r == 7);
    return b;
  endfunction

  always @(negedge clk) begin
    ncyc++;
    cur = {out_data, out_strb, out_burst_num, out_row, out_col, out_last};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {out_valid, cur}, {1'b1, prev});
      if (tile_valid && tile_ready) begin
        for (int r = 0; r < 8; r++) q.push_back(f_exp(tile_data, m_dt, m_rc, m_s, r));
        m_s++;
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", 320'(q.size() > 0), 320'(1));
        if (q.size() > 0) begin
          expb = q.pop_front();
          chk("beat", cur, expb);
        end
        sv_data[out_burst_num] = out_data;
        sv_strb[out_burst_num] = out_strb;
        sv_row[out_burst_num]  = out_row;
        sv_col[out_burst_num]  = out_col;
        sv_last[out_burst_num] = out_last;
        beats_seen++;
        last_beat_n = ncyc;
      end
      if (done) begin
        done_cnt++;
        done_n = ncyc;
      end
      prev_stall = out_valid && !out_ready;
      prev       = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int sub, input int pat);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case (pat)
          0:       tile_data[r][c] = 32'((sub << 8) | (r << 4) | c);
          1:       tile_data[r][c] = $urandom;
          default: tile_data[r][c] = 32'hABCD_EF90 | 32'(c);
        endcase
  endtask

  // Runs one tile; stop_at>=0 returns once that many beats were seen, spur_at>=0 fires an extra start.
  task automatic run_tile(input type_t dt, input logic [1:0] shape, input int pat, input bit bp,
                          input int stop_at, input int spur_at);
    int sub, d0;
    bit hs, fin;
    m_dt = dt; m_rc = shape; m_s = 0; beats_seen = 0; d0 = done_cnt; sub = 0; fin = 1'b0;
    q.delete();
    fill(0, pat);
    data_type  = dt;
    rc         = shape;
    start      = 1'b1;
    tile_valid = 1'b1;
    out_ready  = 1'b1;
    start_n    = ncyc + 1;
    for (int n = 0; n < 3000; n++) begin
      hs = tile_valid && tile_ready;
      tick();
      start = 1'b0;
      if (n == spur_at) begin
        data_type = FP32;
        rc        = 2'b10;
        start     = 1'b1;
      end
      if (hs) begin
        sub++;
        fill(sub, pat);
      end
      if (bp) begin
        tile_valid = 1'($urandom_range(0, 1));
        out_ready  = ($urandom_range(0, 2) != 0);
      end
      if (done_cnt != d0 || (stop_at >= 0 && beats_seen >= stop_at)) begin
        fin = 1'b1;
        break;
      end
    end
    chk("tile_finished", 320'(fin), 320'(1));
    tile_valid = 1'b0;
    out_ready  = 1'b1;
    if (stop_at < 0) begin
      chk("beat_count", 320'(beats_seen), 320'(32));
      chk("queue_drained", 320'(q.size()), 320'(0));
      chk("done_once", 320'(done_cnt - d0), 320'(1));
    end
  endtask

  initial begin
    logic [255:0] exp_d;
    int           dc;
    rst_n = 1'b0; start = 1'b0; data_type = FP32; rc = 2'b00;
    tile_valid = 1'b0; out_ready = 1'b1; tile_data = '0;
    repeat (3) tick();
    chk("reset_state", {busy, done, err, tile_ready, out_valid, out_last, out_data, out_strb,
                        out_burst_num, out_row, out_col}, '0);
    rst_n = 1'b1;
    repeat (2) tick();

    // FP32 M32N8, full throughput
    run_tile(FP32, 2'b00, 0, 1'b0, -1, -1);
    chk("t1_latency_last", 320'(last_beat_n - start_n), 320'(36));
    chk("t1_done_after_last", 320'(done_n - last_beat_n), 320'(1));
    for (int c = 0; c < 8; c++) exp_d[c*32 +: 32] = 32'h150 | 32'(c);
    chk("t1_b13_data", sv_data[13], exp_d);
    chk("t1_b13_rowcol", {sv_row[13], sv_col[13], sv_strb[13]}, {5'd13, 5'd0, 32'hFFFF_FFFF});
    chk("t1_last_flags", {sv_last[30], sv_last[31]}, 2'b01);
    tick();
    chk("t1_idle_after", {busy, done}, 2'b00);

    // FP16 M16N16
    run_tile(FP16, 2'b01, 1, 1'b0, -1, -1);
    for (int r = 0; r < 8; r++) begin
      chk("t2_s1_rowcol", {sv_row[8+r], sv_col[8+r]}, {5'(r), 5'd8});
      chk("t2_s2_rowcol", {sv_row[16+r], sv_col[16+r]}, {5'(8+r), 5'd0});
    end
    chk("t2_upper_zero", 320'(sv_data[20][255:128]), '0);
    chk("t2_strb", sv_strb[20], 32'h0000_FFFF);

    // INT4 M8N32
    run_tile(INT4, 2'b10, 2, 1'b0, -1, -1);
    chk("t3_nibbles", sv_data[5], 256'h7654_3210);
    chk("t3_strb", sv_strb[5], 32'h0000_000F);
    chk("t3_s3_col", {sv_col[24], sv_col[31], sv_row[31]}, {5'd24, 5'd24, 5'd7});

    // Backpressure on both sides
    for (int i = 0; i < 3; i++)
      run_tile(type_t'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 1, 1'b1, -1, -1);

    // Rejected shape
    tick();
    data_type = FP32; rc = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_pulse", {err, busy, tile_ready}, 3'b100);
    tick();
    chk("err_one_cycle", {err, busy}, 2'b00);

    // Start while busy is ignored; scoreboard keeps INT8/M32N8
    run_tile(INT8, 2'b00, 1, 1'b0, -1, 5);
    chk("spur_strb", sv_strb[20], 32'h0000_00FF);

    // Asynchronous reset mid-tile
    dc = done_cnt;
    run_tile(FP32, 2'b00, 1, 1'b0, 10, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {busy, done, err, tile_ready, out_valid, out_last, out_data, out_strb,
                        out_burst_num, out_row, out_col}, '0);
    q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("no_done_on_reset", 320'(done_cnt), 320'(dc));
    run_tile(FP16, 2'b10, 1, 1'b1, -1, -1);
    chk("post_reset_first_beat", {sv_row[0], sv_col[0]}, {5'd0, 5'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
